// File: rtl/hamming74_serial_tx_pkg.sv
// Shared definitions for the Hamming(7,4) serial transmitter: widths, FSM codes, encoder.
package hamming74_serial_tx_pkg;

    localparam int unsigned BAUD_DIV_DEF = 4;
    localparam int unsigned DATA_W       = 4;
    localparam int unsigned CW_W         = 7;
    localparam int unsigned BIT_IDX_W    = 3;
    localparam int unsigned STATE_W      = 2;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [0:CW_W-1]    cw_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;

    // Index 0 is the first code bit on the line; parity bits sit at 0, 1 and 3.
    function automatic cw_t ham74_encode(input logic [DATA_W-1:0] d);
        cw_t cw;
        cw[2] = d[3];
        cw[4] = d[2];
        cw[5] = d[1];
        cw[6] = d[0];
        cw[0] = d[3] ^ d[2] ^ d[0];
        cw[1] = d[3] ^ d[1] ^ d[0];
        cw[3] = d[2] ^ d[1] ^ d[0];
        return cw;
    endfunction

endpackage

// File: rtl/hamming74_encode.sv
// Pure combinational Hamming(7,4) encoder.
module hamming74_encode
    import hamming74_serial_tx_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic [0:CW_W-1]   cw
);

    // Map the nibble to its codeword.
    always_comb begin
        cw = ham74_encode(d);
    end

endmodule

// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) transmitter: accepts nibbles, sends framed codewords (start 0, 7 bits, stop 1).
module hamming74_serial_tx
    import hamming74_serial_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx,
    output logic              busy,
    output logic [0:CW_W-1]   cw_out
);

    localparam int unsigned      BAUD_W    = $clog2(BAUD_DIV) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = 3'd6;

    state_t                state_q,   state_d;
    logic [BAUD_W-1:0]     baud_q,    baud_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    cw_t                   cw_q,      cw_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;

    cw_t  enc_cw;
    logic baud_last;
    logic accept;

    hamming74_encode u_encode (
        .d  (data_in),
        .cw (enc_cw)
    );

    assign baud_last = (baud_q == BAUD_LAST);
    assign accept    = data_valid && data_ready;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign cw_out    = cw_q;

    // Ready in IDLE and in the final STOP cycle so frames can chain without a gap.
    always_comb begin
        data_ready = 1'b0;
        if (!rst) begin
            data_ready = (state_q == IDLE) || ((state_q == STOP) && baud_last);
        end
    end

    // Next state, baud/bit counters and codeword capture.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        cw_d      = cw_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cw_d    = enc_cw;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (accept) begin
                        cw_d    = enc_cw;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level and busy for the upcoming cycle, derived from the next state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cw_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            cw_q      <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            cw_q      <= cw_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// Self-checking bench for hamming74_serial_tx (BAUD_DIV=4 and BAUD_DIV=1 instances).
module tb_hamming74_serial_tx;

    logic       clk;
    logic       rst;

    logic [3:0] d4_in;
    logic       d4_valid, d4_ready, d4_tx, d4_busy;
    logic [0:6] d4_cw;

    logic [3:0] d1_in;
    logic       d1_valid, d1_ready, d1_tx, d1_busy;
    logic [0:6] d1_cw;

    int n_tests;
    int n_fail;

    hamming74_serial_tx #(.BAUD_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(d4_in), .data_valid(d4_valid),
        .data_ready(d4_ready), .tx(d4_tx), .busy(d4_busy), .cw_out(d4_cw)
    );

    hamming74_serial_tx #(.BAUD_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(d1_in), .data_valid(d1_valid),
        .data_ready(d1_ready), .tx(d1_tx), .busy(d1_busy), .cw_out(d1_cw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic Hamming code: 1-based positions, parity at powers of two covers positions with that bit set.
    function automatic logic [0:6] model_cw(input logic [3:0] d);
        logic [0:6] c;
        logic       par;
        c    = '0;
        c[2] = d[3];
        c[4] = d[2];
        c[5] = d[1];
        c[6] = d[0];
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int q = 1; q <= 7; q++) begin
                if (((q & p) != 0) && (q != p)) par = par ^ c[q-1];
            end
            c[p-1] = par;
        end
        return c;
    endfunction

    // Syndrome = XOR of positions holding a 1; zero for a valid codeword.
    function automatic logic [2:0] syndrome(input logic [0:6] c);
        logic [2:0] s;
        s = '0;
        for (int q = 1; q <= 7; q++) begin
            if (c[q-1]) s = s ^ 3'(q);
        end
        return s;
    endfunction

    // Line level for frame slot idx: 0 start, 1..7 code bits, 8 stop.
    function automatic logic line_bit(input logic [0:6] c, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 8) return 1'b1;
        return c[idx-1];
    endfunction

    // Send one nibble on the BAUD_DIV=4 instance and check every cycle; optional foreign pulse during DATA.
    task automatic send_frame4(input logic [3:0] nib, input bit inject, input logic [3:0] inj_nib,
                               output logic [8:0] line);
        logic [0:6] exp;
        logic [2:0] got_v, exp_v;
        exp = model_cw(nib);
        line = '0;
        n_tests++;
        if (d4_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b expected 1", d4_ready);
        end
        d4_in    = nib;
        d4_valid = 1'b1;
        @(negedge clk);
        d4_valid = 1'b0;
        d4_in    = 4'($urandom);
        for (int k = 0; k < 36; k++) begin
            got_v = {d4_tx, d4_busy, d4_ready};
            exp_v = {line_bit(exp, k / 4), 1'b1, (k == 35)};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL frame4 nib=%h cycle %0d {tx,busy,ready}: got %b expected %b", nib, k, got_v, exp_v);
            end
            if ((k % 4) == 2) line[k/4] = d4_tx;
            if (inject && k >= 12 && k <= 16) begin
                d4_valid = 1'b1;
                d4_in    = inj_nib;
            end else begin
                d4_valid = 1'b0;
            end
            @(negedge clk);
        end
        got_v = {d4_tx, d4_busy, d4_ready};
        n_tests++;
        if (got_v !== 3'b101) begin
            n_fail++;
            $display("FAIL frame4_end nib=%h {tx,busy,ready}: got %b expected 101", nib, got_v);
        end
        n_tests++;
        if (d4_cw !== exp) begin
            n_fail++;
            $display("FAIL cw_hold nib=%h: got %b expected %b", nib, d4_cw, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d4_valid = 1'b0; d4_in = '0;
        d1_valid = 1'b0; d1_in = '0;
        @(negedge clk);
        n_tests++;
        if ({d4_tx, d4_busy, d4_ready, d1_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_outputs {tx,busy,ready4,ready1}: got %b expected 1000",
                     {d4_tx, d4_busy, d4_ready, d1_ready});
        end
        n_tests++;
        if (d4_cw !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_cw: got %b expected 0000000", d4_cw);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({d4_ready, d1_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b expected 11", {d4_ready, d1_ready});
        end
        // Abandon a frame mid-flight.
        d4_in    = 4'($urandom);
        d4_valid = 1'b1;
        @(negedge clk);
        d4_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (d4_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_busy: got %b expected 1", d4_busy);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({d4_tx, d4_busy, d4_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset {tx,busy,ready}: got %b expected 100", {d4_tx, d4_busy, d4_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({d4_tx, d4_busy, d4_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL idle_after_reset {tx,busy,ready}: got %b expected 101", {d4_tx, d4_busy, d4_ready});
        end
    endtask

    task automatic test_encode();
        logic [8:0] line;
        logic [0:6] c;
        logic [0:6] lit;
        int         order[16];
        int         tmp, j;
        // Known vectors.
        send_frame4(4'b1011, 1'b0, 4'h0, line);
        lit = 7'b0110011;
        n_tests++;
        if (d4_cw !== lit) begin n_fail++; $display("FAIL enc_1011: got %b expected %b", d4_cw, lit); end
        send_frame4(4'h0, 1'b0, 4'h0, line);
        lit = 7'b0000000;
        n_tests++;
        if (d4_cw !== lit) begin n_fail++; $display("FAIL enc_0: got %b expected %b", d4_cw, lit); end
        send_frame4(4'hF, 1'b0, 4'h0, line);
        lit = 7'b1111111;
        n_tests++;
        if (d4_cw !== lit) begin n_fail++; $display("FAIL enc_F: got %b expected %b", d4_cw, lit); end
        // All nibbles in shuffled order, decoded from the line.
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            send_frame4(4'(order[i]), 1'b0, 4'h0, line);
            c = line[7:1];
            for (int b = 0; b < 7; b++) c[b] = line[b+1];
            n_tests++;
            if (syndrome(c) !== 3'b000 || {c[2], c[4], c[5], c[6]} !== 4'(order[i])
                || line[0] !== 1'b0 || line[8] !== 1'b1) begin
                n_fail++;
                $display("FAIL decode nib=%h: line %b syndrome %b data %b", 4'(order[i]), line, syndrome(c),
                         {c[2], c[4], c[5], c[6]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] nibs[3];
        logic [0:6] exp;
        logic [2:0] got_v, exp_v;
        int         pulses;
        nibs[0] = 4'h3; nibs[1] = 4'hC; nibs[2] = 4'h5;
        pulses = 0;
        d4_in    = nibs[0];
        d4_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 108; k++) begin
            exp   = model_cw(nibs[k / 36]);
            got_v = {d4_tx, d4_busy, d4_ready};
            exp_v = {line_bit(exp, (k % 36) / 4), 1'b1, ((k % 36) == 35)};
            if (d4_ready === 1'b1) pulses++;
            n_tests++;
            if (got_v !== exp_v || d4_cw !== exp) begin
                n_fail++;
                $display("FAIL b2b cycle %0d {tx,busy,ready}/cw: got %b/%b expected %b/%b", k, got_v, d4_cw, exp_v, exp);
            end
            if (k == 0)   d4_in = nibs[1];
            if (k == 36)  d4_in = nibs[2];
            if (k == 107) d4_valid = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_ready_pulses: got %0d expected 3", pulses);
        end
        n_tests++;
        if ({d4_tx, d4_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_idle {tx,busy}: got %b expected 10", {d4_tx, d4_busy});
        end
    endtask

    task automatic test_ignore_busy();
        logic [8:0] line;
        logic [3:0] a, b;
        for (int t = 0; t < 3; t++) begin
            a = 4'($urandom);
            b = a ^ 4'($urandom_range(15, 1));
            send_frame4(a, 1'b1, b, line);
        end
        n_tests++;
        if (d4_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_queue busy: got %b expected 0", d4_busy);
        end
    endtask

    task automatic test_baud1();
        logic [0:6] exp;
        logic [0:6] lit;
        logic [3:0] nibs[2];
        logic [2:0] got_v, exp_v;
        nibs[0] = 4'b0110;
        nibs[1] = 4'($urandom);
        // Single frame.
        d1_in    = nibs[0];
        d1_valid = 1'b1;
        @(negedge clk);
        d1_valid = 1'b0;
        exp = model_cw(nibs[0]);
        lit = 7'b1100110;
        n_tests++;
        if (d1_cw !== lit) begin n_fail++; $display("FAIL enc1_0110: got %b expected %b", d1_cw, lit); end
        for (int k = 0; k < 9; k++) begin
            got_v = {d1_tx, d1_busy, d1_ready};
            exp_v = {line_bit(exp, k), 1'b1, (k == 8)};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL baud1 cycle %0d {tx,busy,ready}: got %b expected %b", k, got_v, exp_v);
            end
            @(negedge clk);
        end
        n_tests++;
        if ({d1_tx, d1_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL baud1_end {tx,busy}: got %b expected 10", {d1_tx, d1_busy});
        end
        // Two chained frames: continuous 9-cycle period.
        d1_in    = nibs[0];
        d1_valid = 1'b1;
        @(negedge clk);
        d1_in = nibs[1];
        for (int k = 0; k < 18; k++) begin
            exp   = model_cw(nibs[k / 9]);
            got_v = {d1_tx, d1_busy, d1_ready};
            exp_v = {line_bit(exp, k % 9), 1'b1, ((k % 9) == 8)};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL baud1_b2b cycle %0d {tx,busy,ready}: got %b expected %b", k, got_v, exp_v);
            end
            if (k == 17) d1_valid = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if ({d1_tx, d1_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL baud1_b2b_end {tx,busy}: got %b expected 10", {d1_tx, d1_busy});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_encode();
        test_back_to_back();
        test_ignore_busy();
        test_baud1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
